// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one word request at a time
// and buffers returned instructions in a small FIFO in front of decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic [5:0]  opcode,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic push;
    logic pop;
    logic credit_ok;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        imem_req   = 1'b0;
        pop        = instr_valid && instr_ready;
        push       = (state_q == WAIT) && imem_rvalid && !redirect;

        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CW'(push) - CW'(pop);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
        end

        // Nothing is outstanding after this cycle, so credit depends on occupancy only.
        credit_ok = (count_d < CW'(DEPTH));

        case (state_q)
            IDLE: begin
                if (!redirect && credit_ok) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    state_d = imem_ready ? DROP : IDLE;
                end else if (imem_ready) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? IDLE : DROP;
                end else if (imem_rvalid) begin
                    state_d = credit_ok ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // The fetch PC already advanced on acceptance, so the returning word sits 4 bytes back.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= imem_rdata;
            pc_q[wr_ptr_q]   <= fetch_pc_q - 32'd4;
        end
    end

    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? data_q[rd_ptr_q] : 32'd0;
    assign instr_pc    = instr_valid ? pc_q[rd_ptr_q] : 32'd0;
    assign pc_plus4    = instr_valid ? (pc_q[rd_ptr_q] + 32'd4) : 32'd0;
    assign opcode      = instr[31:26];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table-driven startup trace, directed
// redirect/reset corner cases and a randomized run against a stream-level model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        instrValid;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic [31:0] pcPlus4;
    logic [5:0]  opcode;
    logic        instrReady;
    logic        redirect;
    logic [31:0] redirectPc;

    logic        wReq;
    logic [31:0] wAddr;
    logic        wReady;
    logic        wRvalid;
    logic [31:0] wRdata;
    logic        wValid;
    logic [31:0] wInstr;
    logic [31:0] wPc;
    logic [31:0] wPcPlus4;
    logic [5:0]  wOpcode;
    logic        wInstrReady;
    logic        wRedirect;
    logic [31:0] wRedirectPc;

    int numChecks = 0;
    int numErrors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imemReq), .imem_addr(imemAddr), .imem_ready(imemReady),
        .imem_rvalid(imemRvalid), .imem_rdata(imemRdata),
        .instr_valid(instrValid), .instr(instr), .instr_pc(instrPc),
        .pc_plus4(pcPlus4), .opcode(opcode), .instr_ready(instrReady),
        .redirect(redirect), .redirect_pc(redirectPc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dutWrap (
        .clk(clk), .reset(reset),
        .imem_req(wReq), .imem_addr(wAddr), .imem_ready(wReady),
        .imem_rvalid(wRvalid), .imem_rdata(wRdata),
        .instr_valid(wValid), .instr(wInstr), .instr_pc(wPc),
        .pc_plus4(wPcPlus4), .opcode(wOpcode), .instr_ready(wInstrReady),
        .redirect(wRedirect), .redirect_pc(wRedirectPc)
    );

    // Memory model state: one outstanding request, fixed or random latency.
    bit          memBusy = 0;
    int          memDelay = 0;
    logic [31:0] memAddr = '0;
    int          memLatency = 1;
    bit          randReady = 0;
    bit          lastAccept = 0;
    bit          lastRvalid = 0;
    logic [31:0] lastAddr = '0;
    bit          wPending = 0;
    bit          wLastAccept = 0;
    logic [31:0] wMemAddr = '0;
    logic [31:0] wLastAddr = '0;
    logic [31:0] wAddrLog[$];
    logic [31:0] wPcLog[$];
    logic [31:0] wP4Log[$];

    typedef struct {
        logic        instrReady;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc;
    } vecT;

    function automatic logic [31:0] wordFor(input logic [31:0] a);
        if (a == 32'h0) return 32'h8C22_0004;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        numChecks++;
        if (act !== exp) begin
            numErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: update memory from last cycle, drive inputs, then sample at negedge.
    task automatic applyStimulus(input logic rst, input logic rdy, input logic redir, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        if (lastRvalid) memBusy = 0;
        if (lastAccept) begin
            memBusy  = 1;
            memAddr  = lastAddr;
            memDelay = memLatency - 1;
        end else if (memBusy && memDelay > 0) begin
            memDelay--;
        end
        wPending = wLastAccept;
        if (wLastAccept) wMemAddr = wLastAddr;

        reset       = rst;
        instrReady  = rdy;
        redirect    = redir;
        redirectPc  = rpc;
        imemRvalid  = memBusy && (memDelay == 0);
        imemRdata   = imemRvalid ? wordFor(memAddr) : 32'hDEAD_BEEF;
        imemReady   = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        wRvalid     = wPending;
        wRdata      = wordFor(wMemAddr);

        @(negedge clk);
        lastAccept  = imemReq && imemReady;
        lastAddr    = imemAddr;
        lastRvalid  = imemRvalid;
        wLastAccept = wReq && wReady;
        wLastAddr   = wAddr;
        if (wLastAccept) wAddrLog.push_back(wAddr);
        if (wValid) begin
            wPcLog.push_back(wPc);
            wP4Log.push_back(wPcPlus4);
        end
        if (imemReq) checkOutput("oneOutstanding", 32'(memBusy), 32'd0);
    endtask

    task automatic pulseReset(input int n);
        repeat (n) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    // Advance with instr_ready=1 until a request appears; the FIFO must stay empty meanwhile.
    task automatic runUntilReq(input string tag, output int cycles);
        bit seen = 0;
        cycles = 0;
        while (!seen && cycles < 20) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            cycles++;
            checkOutput({tag, " staleHidden"}, 32'(instrValid), 32'd0);
            seen = imemReq;
        end
        checkOutput({tag, " reqSeen"}, 32'(seen), 32'd1);
    endtask

    task automatic runUntilValid(input string tag);
        bit seen = 0;
        int cycles = 0;
        while (!seen && cycles < 20) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            cycles++;
            seen = instrValid;
        end
        checkOutput({tag, " validSeen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecT vecs[8];
        int  acc;
        int  gap;
        logic [31:0] w;
        logic [31:0] expPc;
        logic [31:0] expReqAddr;
        int  pops;

        reset = 1'b1; instrReady = 1'b0; redirect = 1'b0; redirectPc = '0;
        imemReady = 1'b0; imemRvalid = 1'b0; imemRdata = '0;
        wReady = 1'b1; wRvalid = 1'b0; wRdata = '0; wInstrReady = 1'b1;
        wRedirect = 1'b0; wRedirectPc = '0;

        // Startup trace with 1-cycle memory and decode always ready.
        vecs[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 32'h4, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
        vecs[6] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 32'hC, 1'b1, 32'h8};

        pulseReset(3);
        wAddrLog.delete(); wPcLog.delete(); wP4Log.delete();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, vecs[i].instrReady, 1'b0, 32'h0);
            checkOutput($sformatf("row%0d req", i), 32'(imemReq), 32'(vecs[i].expReq));
            if (vecs[i].expReq) checkOutput($sformatf("row%0d addr", i), imemAddr, vecs[i].expAddr);
            checkOutput($sformatf("row%0d valid", i), 32'(instrValid), 32'(vecs[i].expValid));
            w = vecs[i].expValid ? wordFor(vecs[i].expPc) : 32'h0;
            checkOutput($sformatf("row%0d instr", i), instr, w);
            checkOutput($sformatf("row%0d opcode", i), 32'(opcode), 32'(w[31:26]));
            checkOutput($sformatf("row%0d pc", i), instrPc, vecs[i].expValid ? vecs[i].expPc : 32'h0);
            checkOutput($sformatf("row%0d pcPlus4", i), pcPlus4, vecs[i].expValid ? vecs[i].expPc + 32'd4 : 32'h0);
            if (i == 3) checkOutput("opcode35", 32'(opcode), 32'd35);
        end

        checkOutput("wrapReqCount", 32'(wAddrLog.size() >= 2), 32'd1);
        checkOutput("wrapPcCount", 32'(wPcLog.size() >= 1), 32'd1);
        if (wAddrLog.size() >= 2) begin
            checkOutput("wrapAddr0", wAddrLog[0], 32'hFFFF_FFFC);
            checkOutput("wrapAddr1", wAddrLog[1], 32'h0);
        end
        if (wPcLog.size() >= 1) begin
            checkOutput("wrapPc", wPcLog[0], 32'hFFFF_FFFC);
            checkOutput("wrapPcPlus4", wP4Log[0], 32'h0);
        end

        $display("[TB] backpressure");
        pulseReset(2);
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            if (lastAccept) acc++;
        end
        checkOutput("bpFetchCount", 32'(acc), 32'd2);
        checkOutput("bpReqIdle", 32'(imemReq), 32'd0);
        checkOutput("bpHeadValid", 32'(instrValid), 32'd1);
        checkOutput("bpHeadPc", instrPc, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("bpPopHeadPc", instrPc, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("bpNextValid", 32'(instrValid), 32'd1);
        checkOutput("bpNextPc", instrPc, 32'h4);

        $display("[TB] redirect in WAIT");
        pulseReset(2);
        memLatency = 3;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rwReq", 32'(imemReq), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h40);
        memLatency = 1;
        runUntilReq("rw", gap);
        checkOutput("rwGap", 32'(gap), 32'd4);
        checkOutput("rwAddr", imemAddr, 32'h40);
        runUntilValid("rw");
        checkOutput("rwPc", instrPc, 32'h40);
        checkOutput("rwInstr", instr, wordFor(32'h40));

        $display("[TB] redirect in REQ with ready");
        pulseReset(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h103);
        checkOutput("rrReq", 32'(imemReq), 32'd1);
        runUntilReq("rr", gap);
        checkOutput("rrGap", 32'(gap), 32'd3);
        checkOutput("rrAddr", imemAddr, 32'h100);
        runUntilValid("rr");
        checkOutput("rrPc", instrPc, 32'h100);

        $display("[TB] reset in WAIT");
        pulseReset(2);
        memLatency = 3;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("rstReq", 32'(imemReq), 32'd0);
        checkOutput("rstValid", 32'(instrValid), 32'd0);
        checkOutput("rstPc", imemAddr, 32'h0);
        memLatency = 1;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rstLateRvalid", 32'(imemRvalid), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rstNoStalePush", 32'(instrValid), 32'd0);
        checkOutput("rstReqAgain", 32'(imemReq), 32'd1);
        runUntilValid("rst");
        checkOutput("rstFirstPc", instrPc, 32'h0);

        $display("[TB] randomized run");
        pulseReset(2);
        randReady  = 1;
        expPc      = 32'h0;
        expReqAddr = 32'h0;
        pops       = 0;
        for (int i = 0; i < 3000; i++) begin
            logic rdy;
            logic redir;
            logic [31:0] rpc;
            rdy   = 1'($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 24) == 0);
            rpc   = $urandom;
            memLatency = $urandom_range(1, 4);
            applyStimulus(1'b0, rdy, redir, rpc);
            if (lastAccept) begin
                checkOutput("rndReqAddr", imemAddr, expReqAddr);
                if (!redir) expReqAddr = expReqAddr + 32'd4;
            end
            if (instrValid && rdy) begin
                w = wordFor(expPc);
                checkOutput("rndPc", instrPc, expPc);
                checkOutput("rndInstr", instr, w);
                checkOutput("rndPcPlus4", pcPlus4, expPc + 32'd4);
                checkOutput("rndOpcode", 32'(opcode), 32'(w[31:26]));
                expPc = expPc + 32'd4;
                pops++;
            end
            if (redir) begin
                expPc      = {rpc[31:2], 2'b00};
                expReqAddr = {rpc[31:2], 2'b00};
            end
        end
        checkOutput("rndProgress", 32'(pops > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
